branch_pred_unit: RTL and testbench

Parametrised dynamic branch predictor for the pipelined CPU: a direct-mapped branch target buffer with per-entry saturating counters. Sits beside the IF-stage PC mux: predicts next PC in the same cycle as instruction fetch. Trains from resolved branches in MEM, and flags mispredictions so the pipeline flushes and redirects. Replaces the always-not-taken policy; the MEM-resolved flush path becomes a mispredict-only path.

---
 rtl/branch_pred_unit.sv | 108 ++++++++++
 tb/tb_branch_pred_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/branch_pred_unit.sv
// Direct-mapped BTB with per-entry saturating counters: zero-latency lookup at fetch, training from MEM.
// Optional macro BPU_STATS_EN adds saturating resolved-branch and mispredict counters.
module branch_pred_unit #(
   parameter int ENTRIES = 16,
   parameter int PC_W    = 32,
   parameter int CNT_W   = 2
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [PC_W-1:0] pc_i,
   output logic            hit_o,
   output logic            pred_taken_o,
   output logic [PC_W-1:0] pred_target_o,
   input  logic            upd_valid_i,
   input  logic [PC_W-1:0] upd_pc_i,
   input  logic            upd_taken_i,
   input  logic [PC_W-1:0] upd_target_i,
   input  logic            upd_pred_taken_i,
   input  logic [PC_W-1:0] upd_pred_target_i,
   output logic            mispredict_o,
   output logic [PC_W-1:0] redirect_pc_o,
   output logic [31:0]     stat_branches_o,
   output logic [31:0]     stat_mispred_o
);
   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = PC_W - IDX_W - 2;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1) << (CNT_W - 1);
   localparam logic [CNT_W-1:0] CNT_WNT = CNT_WT - CNT_W'(1);

   logic             r_valid  [ENTRIES];
   logic [TAG_W-1:0] r_tag    [ENTRIES];
   logic [PC_W-1:0]  r_target [ENTRIES];
   logic [CNT_W-1:0] r_cnt    [ENTRIES];

   logic [IDX_W-1:0] w_idx;
   logic [TAG_W-1:0] w_tag;
   logic [IDX_W-1:0] w_uidx;
   logic [TAG_W-1:0] w_utag;
   logic             w_uhit;
   logic [PC_W-1:0]  w_actual_pc;
   logic             w_unused;

   assign w_idx  = pc_i[IDX_W+1:2];
   assign w_tag  = pc_i[PC_W-1:IDX_W+2];
   assign w_uidx = upd_pc_i[IDX_W+1:2];
   assign w_utag = upd_pc_i[PC_W-1:IDX_W+2];
   assign w_uhit = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);

   // Direction prediction travels down the pipe only for debug; the target alone decides a mispredict.
   assign w_unused = &{1'b0, pc_i[1:0], upd_pc_i[1:0], upd_pred_taken_i};

   assign hit_o         = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign pred_taken_o  = hit_o && r_cnt[w_idx][CNT_W-1];
   assign pred_target_o = hit_o ? r_target[w_idx] : pc_i + PC_W'(4);

   assign w_actual_pc   = upd_taken_i ? upd_target_i : upd_pc_i + PC_W'(4);
   assign mispredict_o  = upd_valid_i && (upd_pred_target_i != w_actual_pc);
   assign redirect_pc_o = w_actual_pc;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_valid[i]  <= 1'b0;
            r_tag[i]    <= '0;
            r_target[i] <= '0;
            r_cnt[i]    <= CNT_WNT;
         end
      end else if (upd_valid_i) begin
         if (w_uhit) begin
            if (upd_taken_i) begin
               r_target[w_uidx] <= upd_target_i;
               if (r_cnt[w_uidx] != CNT_MAX) r_cnt[w_uidx] <= r_cnt[w_uidx] + CNT_W'(1);
            end else if (r_cnt[w_uidx] != '0) begin
               r_cnt[w_uidx] <= r_cnt[w_uidx] - CNT_W'(1);
            end
         end else if (upd_taken_i) begin
            // Allocation replaces whatever alias lived in this slot.
            r_valid[w_uidx]  <= 1'b1;
            r_tag[w_uidx]    <= w_utag;
            r_target[w_uidx] <= upd_target_i;
            r_cnt[w_uidx]    <= CNT_WT;
         end
      end
   end

`ifdef BPU_STATS_EN
   logic [31:0] r_stat_br;
   logic [31:0] r_stat_mp;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_stat_br <= '0;
         r_stat_mp <= '0;
      end else if (upd_valid_i) begin
         if (r_stat_br != 32'hFFFF_FFFF) r_stat_br <= r_stat_br + 32'd1;
         if (mispredict_o && (r_stat_mp != 32'hFFFF_FFFF)) r_stat_mp <= r_stat_mp + 32'd1;
      end
   end

   assign stat_branches_o = r_stat_br;
   assign stat_mispred_o  = r_stat_mp;
`else
   assign stat_branches_o = '0;
   assign stat_mispred_o  = '0;
`endif

endmodule

// File: tb/tb_branch_pred_unit.sv
// Directed bench for branch_pred_unit (ENTRIES=16, PC_W=32, CNT_W=2) with hand-computed expectations.
module tb_branch_pred_unit;
  logic        clk;
  logic        rst_i;
  logic [31:0] pc_i;
  logic        hit_o;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic [31:0] upd_target_i;
  logic        upd_pred_taken_i;
  logic [31:0] upd_pred_target_i;
  logic        mispredict_o;
  logic [31:0] redirect_pc_o;
  logic [31:0] stat_branches_o;
  logic [31:0] stat_mispred_o;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int n_exp_mp = 0;

  branch_pred_unit #(.ENTRIES(16), .PC_W(32), .CNT_W(2)) dut (
    .clk_i(clk), .rst_i(rst_i), .pc_i(pc_i),
    .hit_o(hit_o), .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o),
    .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i),
    .upd_target_i(upd_target_i), .upd_pred_taken_i(upd_pred_taken_i),
    .upd_pred_target_i(upd_pred_target_i),
    .mispredict_o(mispredict_o), .redirect_pc_o(redirect_pc_o),
    .stat_branches_o(stat_branches_o), .stat_mispred_o(stat_mispred_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                     input logic ptk, input logic [31:0] ptgt);
    upd_valid_i       = 1'b1;
    upd_pc_i          = pc;
    upd_taken_i       = tk;
    upd_target_i      = tgt;
    upd_pred_taken_i  = ptk;
    upd_pred_target_i = ptgt;
  endtask

  task automatic idle();
    upd_valid_i = 1'b0;
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic eh,
                      input logic ept, input logic [31:0] etgt);
    pc_i = pc;
    #1;
    chk({tag, "_hit"}, 32'(hit_o), 32'(eh));
    chk({tag, "_taken"}, 32'(pred_taken_o), 32'(ept));
    chk({tag, "_target"}, pred_target_o, etgt);
  endtask

  initial begin
    rst_i = 1'b1; pc_i = '0;
    upd_valid_i = 1'b0; upd_pc_i = '0; upd_taken_i = 1'b0; upd_target_i = '0;
    upd_pred_taken_i = 1'b0; upd_pred_target_i = '0;
    tick();
    rst_i = 1'b0;

    // cold lookup
    look("cold", 32'h40, 1'b0, 1'b0, 32'h44);
    chk("rst_stat_br", stat_branches_o, 32'd0);
    chk("rst_stat_mp", stat_mispred_o, 32'd0);

    // first taken branch allocates; counter = 2
    upd(32'h40, 1'b1, 32'h80, 1'b0, 32'h44);
    #1;
    chk("alloc_mp", 32'(mispredict_o), 32'd1);
    chk("alloc_redirect", redirect_pc_o, 32'h80);
    chk("alloc_same_cycle_hit", 32'(hit_o), 32'd0);
    tick(); idle();
    look("after_alloc", 32'h40, 1'b1, 1'b1, 32'h80);

    // three correct taken updates saturate counter at 3
    for (int i = 0; i < 3; i++) begin
      upd(32'h40, 1'b1, 32'h80, 1'b1, 32'h80);
      #1;
      chk("sat_up_mp", 32'(mispredict_o), 32'd0);
      tick();
    end
    idle();

    // not-taken: 3 -> 2, still predicts taken
    upd(32'h40, 1'b0, 32'h80, 1'b1, 32'h80);
    #1;
    chk("nt1_mp", 32'(mispredict_o), 32'd1);
    chk("nt1_redirect", redirect_pc_o, 32'h44);
    tick(); idle();
    look("after_nt1", 32'h40, 1'b1, 1'b1, 32'h80);

    // not-taken: 2 -> 1, flips to not-taken; target kept on hit
    upd(32'h40, 1'b0, 32'h80, 1'b1, 32'h80);
    tick(); idle();
    look("after_nt2", 32'h40, 1'b1, 1'b0, 32'h80);

    // 1 -> 0 correctly predicted, then 0 stays 0
    upd(32'h40, 1'b0, 32'h80, 1'b0, 32'h44);
    #1;
    chk("nt3_mp", 32'(mispredict_o), 32'd0);
    tick();
    upd(32'h40, 1'b0, 32'h80, 1'b0, 32'h44);
    tick(); idle();
    look("sat_low", 32'h40, 1'b1, 1'b0, 32'h80);

    // 0 -> 1 -> 2 with new target overwriting
    upd(32'h40, 1'b1, 32'h90, 1'b0, 32'h44);
    tick(); idle();
    look("up_to_1", 32'h40, 1'b1, 1'b0, 32'h90);
    upd(32'h40, 1'b1, 32'h90, 1'b0, 32'h44);
    tick(); idle();
    look("up_to_2", 32'h40, 1'b1, 1'b1, 32'h90);

    // aliasing: 0x80 shares index 0 with a different tag
    upd(32'h80, 1'b1, 32'hC0, 1'b0, 32'h84);
    #1;
    chk("alias_mp", 32'(mispredict_o), 32'd1);
    tick(); idle();
    look("alias_old", 32'h40, 1'b0, 1'b0, 32'h44);
    look("alias_new", 32'h80, 1'b1, 1'b1, 32'hC0);

    // same-cycle lookup sees pre-edge state
    upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
    look("same_cyc_pre", 32'h100, 1'b0, 1'b0, 32'h104);
    tick(); idle();
    look("same_cyc_post", 32'h100, 1'b1, 1'b1, 32'h200);

    // reset beats a same-cycle allocation; mispredict stays combinational
    rst_i = 1'b1;
    upd(32'h140, 1'b1, 32'h300, 1'b0, 32'h144);
    #1;
    chk("rst_mp_comb", 32'(mispredict_o), 32'd1);
    tick(); idle();
    rst_i = 1'b0;
    look("rst_cold_100", 32'h100, 1'b0, 1'b0, 32'h104);
    look("rst_drop_140", 32'h140, 1'b0, 1'b0, 32'h144);
    chk("rst2_stat_br", stat_branches_o, 32'd0);

    // address wrap at top of space
    look("wrap_lookup", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
    upd(32'hFFFF_FFFC, 1'b0, 32'h10, 1'b0, 32'h0);
    #1;
    chk("wrap_mp", 32'(mispredict_o), 32'd0);
    chk("wrap_redirect", redirect_pc_o, 32'h0);
    tick();

    // nine more updates, three of them mispredicted (ten total since reset)
    for (int i = 0; i < 9; i++) begin
      if (i % 3 == 1) begin
        upd(32'h400, 1'b0, 32'h0, 1'b1, 32'h999);
        n_exp_mp++;
      end else begin
        upd(32'h400, 1'b0, 32'h0, 1'b0, 32'h404);
      end
      #1;
      chk("stat_mp_bit", 32'(mispredict_o), (i % 3 == 1) ? 32'd1 : 32'd0);
      tick();
    end
    idle();
    #1;
    look("nt_miss_noalloc", 32'h400, 1'b0, 1'b0, 32'h404);
`ifdef BPU_STATS_EN
    chk("stat_branches", stat_branches_o, 32'd10);
    chk("stat_mispred", stat_mispred_o, 32'(n_exp_mp));
`else
    chk("stat_branches_off", stat_branches_o, 32'd0);
    chk("stat_mispred_off", stat_mispred_o, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
